// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl
// Brief    : Edge-latched, maskable, fixed-priority interrupt request
//            controller driving the CPU intr/inta handshake with EOI gating.
// Revision : 1.0 - initial release
// ============================================================================
module intr_ctrl #(
   parameter int          N     = 8,
   parameter logic [31:0] VBASE = 32'h0000_0008
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [N-1:0] irq,
   input  logic         inta,
   input  logic         eoi,
   input  logic         mwe,
   input  logic [N-1:0] mwd,
   output logic         intr,
   output logic [2:0]   id,
   output logic [31:0]  vector,
   output logic [N-1:0] mask,
   output logic [N-1:0] pending,
   output logic         busy
);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_req  = 2'd1;
   localparam logic [1:0] c_st_serv = 2'd2;

   logic [1:0]   r_state;
   logic [N-1:0] r_irq_q;
   logic [N-1:0] r_pending;
   logic [N-1:0] r_mask;
   logic         r_intr;
   logic [2:0]   r_id;
   logic         r_busy;

   logic [N-1:0] w_rise;
   logic [N-1:0] w_act;
   logic [N-1:0] w_mask_nxt;
   logic [7:0]   w_mask_ext;
   logic [7:0]   w_clr_ext;
   logic [2:0]   w_win_id;
   logic         w_any;
   logic         w_ack;

   assign w_rise     = irq & ~r_irq_q;
   assign w_act      = r_pending & r_mask;
   assign w_any      = |w_act;
   assign w_mask_nxt = mwe ? mwd : r_mask;
   assign w_ack      = (r_state == c_st_req) && inta;

   // Lowest-numbered active source wins; scan downward so it is assigned last.
   always_comb begin
      w_win_id = 3'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_act[i]) w_win_id = i[2:0];
      end
   end

   // Widen to 8 bits so indexing by the 3-bit id is always in range.
   always_comb begin
      w_mask_ext        = '0;
      w_mask_ext[N-1:0] = w_mask_nxt;
      w_clr_ext         = '0;
      if (w_ack) w_clr_ext[r_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_irq_q   <= '0;
         r_pending <= '0;
         r_mask    <= '0;
      end else begin
         r_irq_q   <= irq;
         r_pending <= (r_pending & ~w_clr_ext[N-1:0]) | w_rise;
         if (mwe) r_mask <= mwd;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= c_st_idle;
         r_intr  <= 1'b0;
         r_id    <= 3'd0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_any) begin
                  r_id    <= w_win_id;
                  r_intr  <= 1'b1;
                  r_state <= c_st_req;
               end
            end
            c_st_req: begin
               // Acknowledge takes precedence over a same-cycle mask-off.
               if (inta) begin
                  r_intr  <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= c_st_serv;
               end else if (!w_mask_ext[r_id]) begin
                  r_intr  <= 1'b0;
                  r_state <= c_st_idle;
               end
            end
            c_st_serv: begin
               if (eoi) begin
                  r_busy  <= 1'b0;
                  r_state <= c_st_idle;
               end
            end
            default: begin
               r_intr  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign intr    = r_intr;
   assign id      = r_id;
   assign vector  = VBASE + {27'd0, r_id, 2'b00};
   assign mask    = r_mask;
   assign pending = r_pending;
   assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_intr_ctrl
// Brief    : Directed self-checking bench for intr_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intr_ctrl;

   logic        clk;
   logic        clr;
   logic [7:0]  irq;
   logic        inta;
   logic        eoi;
   logic        mwe;
   logic [7:0]  mwd;
   logic        intr;
   logic [2:0]  id;
   logic [31:0] vector;
   logic [7:0]  mask;
   logic [7:0]  pending;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   intr_ctrl #(.N(8), .VBASE(32'h0000_0008)) u_dut (
      .clk     (clk),
      .clr     (clr),
      .irq     (irq),
      .inta    (inta),
      .eoi     (eoi),
      .mwe     (mwe),
      .mwd     (mwd),
      .intr    (intr),
      .id      (id),
      .vector  (vector),
      .mask    (mask),
      .pending (pending),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One active edge, then settle 1ns so outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr = 1'b1; irq = '0; inta = 1'b0; eoi = 1'b0; mwe = 1'b0; mwd = '0;
      tick();
      tick();
      clr = 1'b0;
      check("rst_intr",    32'(intr),    32'h0);
      check("rst_id",      32'(id),      32'h0);
      check("rst_mask",    32'(mask),    32'h0);
      check("rst_pending", 32'(pending), 32'h0);
      check("rst_busy",    32'(busy),    32'h0);
      check("rst_vector",  vector,       32'h8);

      mwe = 1'b1; mwd = 8'hFF;
      tick();
      mwe = 1'b0;
      check("mask_ff", 32'(mask), 32'hFF);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_intr",    32'(intr),    32'h0);
         check("idle_pending", 32'(pending), 32'h0);
         check("idle_busy",    32'(busy),    32'h0);
      end
      check("idle_vector", vector, 32'h8);

      // Single request on source 3
      irq[3] = 1'b1;
      tick();
      check("sr_pend_k",   32'(pending), 32'h08);
      check("sr_intr_k",   32'(intr),    32'h0);
      tick();
      check("sr_intr_k1",  32'(intr),    32'h1);
      check("sr_id_k1",    32'(id),      32'h3);
      check("sr_vec_k1",   vector,       32'h14);
      tick();
      check("sr_hold_k2",  32'(intr),    32'h1);
      inta = 1'b1;
      tick();
      inta = 1'b0;
      check("sr_intr_k3",  32'(intr),    32'h0);
      check("sr_busy_k3",  32'(busy),    32'h1);
      check("sr_pend_k3",  32'(pending), 32'h0);
      tick();
      tick();
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      check("sr_busy_k6",  32'(busy),    32'h0);
      tick();
      check("sr_quiet",    32'(intr),    32'h0);
      irq[3] = 1'b0;

      // inta while idle must do nothing
      inta = 1'b1;
      tick();
      inta = 1'b0;
      check("sp_inta_intr", 32'(intr),    32'h0);
      check("sp_inta_busy", 32'(busy),    32'h0);
      check("sp_inta_pend", 32'(pending), 32'h0);
      tick();
      check("sp_inta_intr2", 32'(intr),   32'h0);

      // Priority without preemption
      irq[5] = 1'b1;
      tick();
      check("pr_pend5", 32'(pending), 32'h20);
      tick();
      check("pr_intr",  32'(intr),    32'h1);
      check("pr_id5",   32'(id),      32'h5);
      irq[1] = 1'b1;
      tick();
      check("pr_pend51", 32'(pending), 32'h22);
      check("pr_id_hold", 32'(id),     32'h5);
      check("pr_intr_hold", 32'(intr), 32'h1);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      check("sp_eoi_intr", 32'(intr),    32'h1);
      check("sp_eoi_id",   32'(id),      32'h5);
      check("sp_eoi_busy", 32'(busy),    32'h0);
      check("sp_eoi_pend", 32'(pending), 32'h22);
      inta = 1'b1;
      tick();
      inta = 1'b0;
      check("pr_ack_busy", 32'(busy),    32'h1);
      check("pr_ack_pend", 32'(pending), 32'h02);
      check("pr_ack_id",   32'(id),      32'h5);
      check("pr_ack_intr", 32'(intr),    32'h0);
      tick();
      check("pr_nonest",   32'(intr),    32'h0);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      check("pr_eoi_busy", 32'(busy),    32'h0);
      check("pr_eoi_intr", 32'(intr),    32'h0);
      tick();
      check("pr_next_intr", 32'(intr),   32'h1);
      check("pr_next_id",   32'(id),     32'h1);
      check("pr_next_vec",  vector,      32'hC);
      inta = 1'b1;
      tick();
      inta = 1'b0;
      check("pr_pend_clr", 32'(pending), 32'h0);
      eoi = 1'b1;
      irq = '0;
      tick();
      eoi = 1'b0;

      // Masking
      mwe = 1'b1; mwd = 8'h00;
      tick();
      mwe = 1'b0;
      irq[2] = 1'b1;
      tick();
      check("mk_pend",  32'(pending), 32'h04);
      check("mk_intr0", 32'(intr),    32'h0);
      tick();
      check("mk_intr1", 32'(intr),    32'h0);
      mwe = 1'b1; mwd = 8'h04;
      tick();
      mwe = 1'b0;
      check("mk_wr_intr", 32'(intr),  32'h0);
      tick();
      check("mk_en_intr", 32'(intr),  32'h1);
      check("mk_en_id",   32'(id),    32'h2);
      mwe = 1'b1; mwd = 8'h00;
      tick();
      mwe = 1'b0;
      check("mk_off_intr", 32'(intr),    32'h0);
      check("mk_off_pend", 32'(pending), 32'h04);
      check("mk_off_mask", 32'(mask),    32'h00);
      tick();
      check("mk_off_intr2", 32'(intr),   32'h0);
      mwe = 1'b1; mwd = 8'hFF;
      tick();
      mwe = 1'b0;
      tick();
      check("mk_re_intr", 32'(intr),  32'h1);
      check("mk_re_id",   32'(id),    32'h2);
      inta = 1'b1;
      tick();
      inta = 1'b0;
      check("mk_ack_pend", 32'(pending), 32'h0);
      eoi = 1'b1;
      irq = '0;
      tick();
      eoi = 1'b0;

      // New edge on the bit being acknowledged
      irq[3] = 1'b1;
      tick();
      tick();
      check("bd_intr", 32'(intr), 32'h1);
      check("bd_id",   32'(id),   32'h3);
      irq[3] = 1'b0;
      tick();
      irq[3] = 1'b1;
      inta = 1'b1;
      tick();
      inta = 1'b0;
      check("bd_pend_kept", 32'(pending), 32'h08);
      check("bd_busy",      32'(busy),    32'h1);
      check("bd_intr0",     32'(intr),    32'h0);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      check("bd_eoi_busy", 32'(busy), 32'h0);
      check("bd_eoi_intr", 32'(intr), 32'h0);
      tick();
      check("bd_again_intr", 32'(intr), 32'h1);
      check("bd_again_id",   32'(id),   32'h3);

      // inta wins over a same-cycle mask-off of the requested source
      inta = 1'b1; mwe = 1'b1; mwd = 8'h00;
      tick();
      inta = 1'b0; mwe = 1'b0;
      check("im_busy", 32'(busy),    32'h1);
      check("im_intr", 32'(intr),    32'h0);
      check("im_mask", 32'(mask),    32'h00);
      check("im_pend", 32'(pending), 32'h00);

      // Reset while in service
      irq[6] = 1'b1;
      tick();
      check("rs_pend", 32'(pending), 32'h40);
      clr = 1'b1;
      irq = '0;
      tick();
      clr = 1'b0;
      check("rs_intr",    32'(intr),    32'h0);
      check("rs_id",      32'(id),      32'h0);
      check("rs_mask",    32'(mask),    32'h0);
      check("rs_pending", 32'(pending), 32'h0);
      check("rs_busy",    32'(busy),    32'h0);
      check("rs_vector",  vector,       32'h8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt request controller: the device-side end of the CPU's `intr`/`inta` handshake. It sits between up to eight peripheral request lines and the single-cycle CPU. It edge-detects and latches requests, applies a software-writable mask, and presents the highest-priority pending source to the CPU on `intr` with its number on `id`. It holds further requests off until the handler signals end-of-interrupt.

## Interface
- `N`, 8: number of request sources (1..8).
- `VBASE`, 32'h0000_0008: vector base; `vector = VBASE + {id, 2'b00}`.

- `clk`  in  1  clock; all state updates on its rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `irq`  in  N  peripheral request lines, level in, rising-edge sensitive.
- `inta`  in  1  CPU interrupt acknowledge, one-cycle pulse.
- `eoi`  in  1  end-of-interrupt pulse from the handler, one cycle.
- `mwe`  in  1  mask write enable.
- `mwd`  in  N  mask write data; 1 = source enabled.
- `intr`  out  1  interrupt request to the CPU, registered.
- `id`  out  3  number of the selected source, registered.
- `vector`  out  32  handler address derived from `id`.
- `mask`  out  N  current mask register.
- `pending`  out  N  latched, unserviced requests.
- `busy`  out  1  a handler is in service.

## Operation
- Edge detect:
  - `irq_q <= irq` each cycle.
  - `rise = irq & ~irq_q`.
  - `pending <= (pending & ~clrbit) | rise`.
  - Set wins over clear on the same bit in the same cycle.
- A second rising edge on an already-pending bit is absorbed. No counting.
- Mask:
  - `mwe` loads `mwd` into `mask` at the edge.
  - Masked sources still latch into `pending` but are not requested.
- Priority: lowest-numbered bit of `pending & mask` wins.
- FSM states: IDLE, REQ, SERV.
  - IDLE: if `pending & mask` is nonzero, latch the winner into `id`, set `intr=1`, and go to REQ.
  - REQ, `inta=1`: clear `pending[id]`, set `intr=0`, set `busy=1`, go to SERV. `id` holds its value.
  - REQ, `mask[id]` becomes 0 without `inta`: set `intr=0` and return to IDLE. `pending[id]` is kept.
  - REQ, otherwise: hold `intr=1`. `id` does not change even if a higher-priority source arrives. There is no preemption.
  - SERV, `eoi=1`: set `busy=0` and go to IDLE. A new request may be raised in the next cycle.
  - SERV: `intr` stays 0 regardless of pending sources. There is no nesting.
- Pulses ignored by state:
  - `inta` in IDLE or SERV.
  - `eoi` in IDLE or REQ.
- Simultaneous `inta` and `mwe` clearing `mask[id]` in REQ: `inta` wins. Go to SERV.
- Simultaneous `eoi` and a new edge: the edge is latched, and IDLE sees it the following cycle.
- `N` < 8: the unused upper `id` values never occur.

## Timing
- Reset (`clr=1` at an edge):
  - `intr=0`, `id=0`, `mask=0`, `pending=0`, `busy=0`, `irq_q=0`, state IDLE.
  - `vector=VBASE`.
- Reset mid-handshake aborts it. All requests are lost.
- Latency, from `irq` rising before edge k (source unmasked, FSM in IDLE):
  - `pending` set after edge k.
  - `intr=1` and `id` valid after edge k+1.
- `inta` sampled high at edge m: `intr=0` after edge m, and `pending[id]` is cleared at the same edge.
- `eoi` sampled at edge e: `busy=0` after edge e. The earliest next `intr` is after edge e+1.
- `vector` is combinational from `id`, with no added latency.

## Test plan
- Reset then idle:
  - Stimulus: hold `clr` 2 cycles, then `mask=8'hFF`, `irq=0`.
  - Required: `intr`, `pending`, `busy` stay 0 for 20 cycles; `vector=32'h8`.
- Single request:
  - Stimulus: `mask=8'hFF`; raise `irq[3]` before edge k; pulse `inta` at edge k+3; pulse `eoi` at k+6.
  - Required: `pending=8'h08` after k; `intr=1`, `id=3`, `vector=32'h14` after k+1; `intr=0`, `busy=1`, `pending=0` after k+3; `busy=0` after k+6.
- Priority and no preemption:
  - Stimulus: raise `irq[5]`; two cycles later raise `irq[1]` while in REQ for 5.
  - Required: `id` stays 5 until `inta`. After `eoi`, the next request has `id=1`.
- Masking:
  - Stimulus: `mask=8'h00`, raise `irq[2]`.
  - Required: `pending=8'h04`, `intr=0`. Writing `mask=8'h04` gives `intr=1` with `id=2` two edges later.
  - Stimulus: then clear `mask` while in REQ.
  - Required: `intr=0` next edge, `pending` still `8'h04`.
- Boundary events:
  - Stimulus: a new `irq[3]` edge in the same cycle `inta` clears `pending[3]`.
  - Required: `pending[3]` stays 1, and `id=3` is requested again after `eoi`.
  - Stimulus: `clr` asserted in SERV.
  - Required: all outputs return to reset values next edge.
- Spurious pulses:
  - Stimulus: `inta` in IDLE; `eoi` in REQ.
  - Required: no state, `pending`, or `busy` change.
